frame_tx_scheduler: RTL and testbench

- Sits between the RHD sample stream and the ESP32 SPI master.
- Packs 16-bit samples into a ping-pong pair of frame buffers and hands each completed frame to the SPI master through a start/busy/done handshake, gated by the ESP32 ready line.
- Stamps every accepted frame with an ID, times out hung transfers, and counts sent, dropped and aborted frames.

---
 rtl/frame_tx_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_frame_tx_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx_scheduler.sv
// Ping-pong frame packer for the RHD sample stream; hands each completed frame
// to the ESP32 SPI master via a start/busy/done handshake with timeout and statistics.
module frame_tx_scheduler #(
    parameter int unsigned WORDS   = 64,
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WORD_W-1:0]         sample_data,
    input  logic                      sample_valid,
    input  logic                      esp_ready,
    output logic                      tx_start,
    input  logic                      tx_done,
    output logic [WORDS*WORD_W-1:0]   tx_frame,
    output logic [ID_W-1:0]           tx_frame_id,
    output logic [31:0]               frame_cnt,
    output logic [15:0]               drop_cnt,
    output logic [15:0]               abort_cnt,
    output logic                      tx_active
);

    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_PENDING,
        BUF_SENDING
    } buf_state_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } tx_state_t;

    logic              esp_meta;
    logic              esp_ready_s;

    logic [WORD_W-1:0] buf_mem [2][WORDS];
    buf_state_t        buf_st  [2];
    logic [ID_W-1:0]   buf_id  [2];

    logic              wr_sel;
    logic [IDX_W-1:0]  wr_idx;
    logic [ID_W-1:0]   id_next;
    logic              rd_sel;
    logic [TMR_W-1:0]  timer;

    tx_state_t         state;
    tx_state_t         state_nxt;

    logic              frame_done;
    logic              other_free;
    logic              accept;
    logic              drop;
    logic              pend_any;
    logic              launch_sel;
    logic              launch;
    logic              release_now;
    logic              abort_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            esp_meta    <= 1'b0;
            esp_ready_s <= 1'b0;
        end else begin
            esp_meta    <= esp_ready;
            esp_ready_s <= esp_meta;
        end
    end

    // The writer's buffer is always EMPTY, so a pending frame normally sits in ~wr_sel.
    always_comb begin
        pend_any   = 1'b0;
        launch_sel = ~wr_sel;
        if (buf_st[~wr_sel] == BUF_PENDING) begin
            pend_any   = 1'b1;
            launch_sel = ~wr_sel;
        end else if (buf_st[wr_sel] == BUF_PENDING) begin
            pend_any   = 1'b1;
            launch_sel = wr_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        release_now = 1'b0;
        abort_now   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_any && esp_ready_s) begin
                    launch    = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    release_now = 1'b1;
                    state_nxt   = ST_IDLE;
                end else if (timer == TMR_LAST) begin
                    release_now = 1'b1;
                    abort_now   = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_active = (state == ST_SEND);
    end

    // A buffer released this cycle counts as free, so a coincident completion is kept.
    always_comb begin
        frame_done = sample_valid && (wr_idx == LAST_IDX);
        other_free = (buf_st[~wr_sel] == BUF_EMPTY) ||
                     (release_now && (rd_sel == ~wr_sel));
        accept     = frame_done && other_free;
        drop       = frame_done && !other_free;
    end

    always_ff @(posedge clk) begin
        if (sample_valid) begin
            buf_mem[wr_sel][wr_idx] <= sample_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel    <= 1'b0;
            wr_idx    <= '0;
            id_next   <= '0;
            buf_id[0] <= '0;
            buf_id[1] <= '0;
        end else if (sample_valid) begin
            if (frame_done) begin
                wr_idx <= '0;
            end else begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (accept) begin
                buf_id[wr_sel] <= id_next;
                id_next        <= id_next + 1'b1;
                wr_sel         <= ~wr_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_st[0] <= BUF_EMPTY;
            buf_st[1] <= BUF_EMPTY;
        end else begin
            if (release_now) begin
                buf_st[rd_sel] <= BUF_EMPTY;
            end
            if (launch) begin
                buf_st[launch_sel] <= BUF_SENDING;
            end
            if (accept) begin
                buf_st[wr_sel] <= BUF_PENDING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel      <= 1'b0;
            timer       <= '0;
            tx_start    <= 1'b0;
            tx_frame_id <= '0;
            frame_cnt   <= '0;
        end else begin
            tx_start <= launch;
            if (launch) begin
                rd_sel      <= launch_sel;
                timer       <= '0;
                tx_frame_id <= buf_id[launch_sel];
                frame_cnt   <= frame_cnt + 1'b1;
            end else if (state == ST_SEND) begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt  <= '0;
            abort_cnt <= '0;
        end else begin
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (abort_now && (abort_cnt != '1)) begin
                abort_cnt <= abort_cnt + 1'b1;
            end
        end
    end

    // The frame register is loaded at launch and held, since the writer never touches a non-EMPTY buffer.
    always_ff @(posedge clk) begin
        if (launch) begin
            for (int unsigned k = 0; k < WORDS; k++) begin
                tx_frame[k*WORD_W +: WORD_W] <= buf_mem[launch_sel][k];
            end
        end
    end

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Directed bench for frame_tx_scheduler: one default instance plus one with a
// short timeout; each checkpoint is an immediate assertion against hand-computed values.
module tb_frame_tx_scheduler;

    localparam int WORDS  = 64;
    localparam int WORD_W = 16;
    localparam int FW     = WORDS * WORD_W;

    logic              clk;
    logic              rst_n;

    logic [WORD_W-1:0] sample_data;
    logic              sample_valid;
    logic              esp_ready;
    logic              tx_start;
    logic              tx_done;
    logic [FW-1:0]     tx_frame;
    logic [7:0]        tx_frame_id;
    logic [31:0]       frame_cnt;
    logic [15:0]       drop_cnt;
    logic [15:0]       abort_cnt;
    logic              tx_active;

    logic [WORD_W-1:0] sample_data2;
    logic              sample_valid2;
    logic              esp_ready2;
    logic              tx_start2;
    logic              tx_done2;
    logic [FW-1:0]     tx_frame2;
    logic [7:0]        tx_frame_id2;
    logic [31:0]       frame_cnt2;
    logic [15:0]       drop_cnt2;
    logic [15:0]       abort_cnt2;
    logic              tx_active2;

    int n_chk;
    int n_fail;

    frame_tx_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .esp_ready    (esp_ready),
        .tx_start     (tx_start),
        .tx_done      (tx_done),
        .tx_frame     (tx_frame),
        .tx_frame_id  (tx_frame_id),
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt),
        .abort_cnt    (abort_cnt),
        .tx_active    (tx_active)
    );

    frame_tx_scheduler #(.TIMEOUT(20)) dut_to (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_data  (sample_data2),
        .sample_valid (sample_valid2),
        .esp_ready    (esp_ready2),
        .tx_start     (tx_start2),
        .tx_done      (tx_done2),
        .tx_frame     (tx_frame2),
        .tx_frame_id  (tx_frame_id2),
        .frame_cnt    (frame_cnt2),
        .drop_cnt     (drop_cnt2),
        .abort_cnt    (abort_cnt2),
        .tx_active    (tx_active2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] getw(input logic [FW-1:0] fr, input int k);
        return fr[k*WORD_W +: WORD_W];
    endfunction

    // Frame f carries word k = {f[7:0], k[7:0]}; gap idle cycles follow each word.
    task automatic stream(input int f, input bit which, input int gap);
        for (int k = 0; k < WORDS; k++) begin
            if (which) begin
                sample_data2  = 16'((f << 8) | k);
                sample_valid2 = 1'b1;
            end else begin
                sample_data   = 16'((f << 8) | k);
                sample_valid  = 1'b1;
            end
            tick();
            if (gap > 0) begin
                if (which) sample_valid2 = 1'b0;
                else       sample_valid  = 1'b0;
                repeat (gap) tick();
            end
        end
        if (which) sample_valid2 = 1'b0;
        else       sample_valid  = 1'b0;
    endtask

    task automatic wait_start(input bit which, input int max, output int n, output bit seen);
        n = 0;
        while (!(which ? tx_start2 : tx_start) && n < max) begin
            tick();
            n++;
        end
        seen = which ? tx_start2 : tx_start;
    endtask

    task automatic pulse_done(input bit which);
        if (which) tx_done2 = 1'b1;
        else       tx_done  = 1'b1;
        tick();
        if (which) tx_done2 = 1'b0;
        else       tx_done  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;  sample_valid2 = 1'b0;
        tx_done = 1'b0;       tx_done2 = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int  n;
        bit  seen;
        int  ids  [3];
        int  sels [3];
        int  w0s  [3];

        n_chk = 0;
        n_fail = 0;
        sample_data = '0;  sample_data2 = '0;
        esp_ready = 1'b1;  esp_ready2 = 1'b1;

        // Reset state
        do_reset();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_active", tx_active, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_abort_cnt", abort_cnt, 0);
        check("rst_frame_id", tx_frame_id, 0);

        // 1. Basic frame with exact start latency
        stream(0, 0, 0);
        wait_start(0, 5, n, seen);
        check("t1_latency", n, 1);
        check("t1_seen", seen, 1);
        check("t1_id", tx_frame_id, 0);
        check("t1_w0", getw(tx_frame, 0), 16'h0000);
        check("t1_w17", getw(tx_frame, 17), 16'h0011);
        check("t1_w63", getw(tx_frame, 63), 16'h003F);
        check("t1_active", tx_active, 1);
        check("t1_frame_cnt", frame_cnt, 1);
        tick();
        check("t1_start_pulse", tx_start, 0);
        pulse_done(0);
        check("t1_released", tx_active, 0);
        check("t1_drop_cnt", drop_cnt, 0);

        // 2. Back-to-back frames, tx_done 100 cycles after each start
        do_reset();
        fork
            begin
                for (int f = 0; f < 3; f++) stream(f, 0, 1);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    wait_start(0, 400, n, seen);
                    check("t2_seen", seen, 1);
                    ids[i]  = int'(tx_frame_id);
                    sels[i] = int'(dut.rd_sel);
                    w0s[i]  = int'(getw(tx_frame, 0));
                    repeat (99) tick();
                    pulse_done(0);
                end
            end
        join
        for (int i = 0; i < 3; i++) begin
            check("t2_id", ids[i], i);
            check("t2_pingpong", sels[i], i % 2);
            check("t2_w0", w0s[i], i << 8);
        end
        check("t2_frame_cnt", frame_cnt, 3);
        check("t2_drop_cnt", drop_cnt, 0);
        check("t2_idle", tx_active, 0);

        // 3. Overrun: only one frame can wait while the writer keeps its own buffer
        esp_ready = 1'b0;
        do_reset();
        for (int f = 0; f < 3; f++) stream(f, 0, 0);
        check("t3_frame_cnt_hold", frame_cnt, 0);
        check("t3_drop_cnt", drop_cnt, 2);
        check("t3_idle", tx_active, 0);
        esp_ready = 1'b1;
        wait_start(0, 8, n, seen);
        check("t3_sync_latency", n, 3);
        check("t3_first_id", tx_frame_id, 0);
        check("t3_first_w0", getw(tx_frame, 0), 16'h0000);
        check("t3_first_w63", getw(tx_frame, 63), 16'h003F);
        tick();
        pulse_done(0);
        stream(3, 0, 0);
        wait_start(0, 5, n, seen);
        check("t3_second_seen", seen, 1);
        check("t3_second_id", tx_frame_id, 1);
        check("t3_second_w0", getw(tx_frame, 0), 16'h0300);
        check("t3_frame_cnt", frame_cnt, 2);
        pulse_done(0);
        check("t3_drop_final", drop_cnt, 2);

        // 4. Timeout on the TIMEOUT=20 instance
        do_reset();
        stream(0, 1, 0);
        wait_start(1, 5, n, seen);
        check("t4_seen", seen, 1);
        check("t4_id", tx_frame_id2, 0);
        n = 0;
        while (tx_active2 && n < 100) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", n, 20);
        check("t4_abort_cnt", abort_cnt2, 1);
        stream(1, 1, 0);
        wait_start(1, 5, n, seen);
        check("t4_next_seen", seen, 1);
        check("t4_next_id", tx_frame_id2, 1);
        check("t4_next_w0", getw(tx_frame2, 0), 16'h0100);
        check("t4_frame_cnt", frame_cnt2, 2);
        tick();
        pulse_done(1);
        check("t4_done_release", tx_active2, 0);
        check("t4_abort_hold", abort_cnt2, 1);

        // 5. Release coinciding with the last word of the next frame
        do_reset();
        fork
            begin
                stream(0, 0, 0);
                stream(1, 0, 0);
            end
            begin
                wait_start(0, 200, n, seen);
                check("t5_first_seen", seen, 1);
                repeat (62) tick();
                pulse_done(0);
            end
        join
        check("t5_drop_cnt", drop_cnt, 0);
        wait_start(0, 5, n, seen);
        check("t5_next_latency", n, 1);
        check("t5_next_id", tx_frame_id, 1);
        check("t5_next_w0", getw(tx_frame, 0), 16'h0100);
        check("t5_frame_cnt", frame_cnt, 2);
        tick();
        pulse_done(0);

        // 6. Asynchronous reset during SEND
        do_reset();
        stream(0, 0, 0);
        wait_start(0, 5, n, seen);
        tick();
        pulse_done(0);
        stream(1, 0, 0);
        wait_start(0, 5, n, seen);
        check("t6_pre_id", tx_frame_id, 1);
        tick();
        check("t6_pre_active", tx_active, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_active", tx_active, 0);
        check("t6_async_frame_cnt", frame_cnt, 0);
        check("t6_async_id", tx_frame_id, 0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        stream(2, 0, 0);
        wait_start(0, 5, n, seen);
        check("t6_post_seen", seen, 1);
        check("t6_post_id", tx_frame_id, 0);
        check("t6_post_w0", getw(tx_frame, 0), 16'h0200);
        check("t6_post_frame_cnt", frame_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
